// File: rtl/seg_scan_display_pkg.sv
// Shared seven-segment codes for the display scanner and the calculator FSM.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_scan_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_E     = 4'hB;
  localparam logic [3:0] CODE_R     = 4'hC;

  localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/seg_scan_display_if.sv
// Digit-code bundle from the calculator and the multiplexed display lines.
// The scanner is the slave; the upstream/board side is the master.
interface seg_scan_display_if;
  logic [3:0] d4;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic       blank_lz;
  logic [3:0] dp_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output d4, d3, d2, d1, blank_lz, dp_sel,
    input  an, seg, dp
  );

  modport slave (
    input  d4, d3, d2, d1, blank_lz, dp_sel,
    output an, seg, dp
  );
endinterface

// File: rtl/seg_scan_display_decode.sv
// 4-bit digit code to active-low seven-segment pattern.
// Codes D..F render blank.
module seg7_decode
  import seg_scan_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:       seg = SEG_0;
      4'h1:       seg = SEG_1;
      4'h2:       seg = SEG_2;
      4'h3:       seg = SEG_3;
      4'h4:       seg = SEG_4;
      4'h5:       seg = SEG_5;
      4'h6:       seg = SEG_6;
      4'h7:       seg = SEG_7;
      4'h8:       seg = SEG_8;
      4'h9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      CODE_E:     seg = SEG_E;
      CODE_R:     seg = SEG_R;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit common-anode driver with per-frame snapshot,
// leading-zero blanking and a dead cycle at every digit switch.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave io
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seg_scan_display: REFRESH_DIV must be >= 2");
    end
  endgenerate

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] snap_d;
  logic            snap_lz;
  logic [3:0]      snap_dp;

  logic [3:0] sel_code;
  logic       sel_blank;
  logic [6:0] dec_seg;
  logic [3:0] blank;
  logic [3:0] nxt_an;
  logic [6:0] nxt_seg;
  logic       nxt_dp;
  logic       frame_start;

  assign frame_start = (cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Inputs are only sampled at frame start so a frame never mixes values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_d  <= '0;
      snap_lz <= 1'b0;
      snap_dp <= 4'h0;
    end else if (frame_start) begin
      snap_d  <= {io.d4, io.d3, io.d2, io.d1};
      snap_lz <= io.blank_lz;
      snap_dp <= io.dp_sel;
    end
  end

  // Blanking ripples right from d4; d1 always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = snap_lz && (snap_d[3] == 4'h0);
    blank[2] = blank[3] && (snap_d[2] == 4'h0);
    blank[1] = blank[2] && (snap_d[1] == 4'h0);
  end

  assign sel_code  = snap_d[idx];
  assign sel_blank = blank[idx];

  seg7_decode u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

  always_comb begin
    nxt_an  = AN_OFF;
    nxt_seg = SEG_BLANK;
    nxt_dp  = 1'b1;
    if (cnt != '0) begin
      nxt_an  = ~(4'b0001 << idx);
      nxt_seg = sel_blank ? SEG_BLANK : dec_seg;
      nxt_dp  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.an  <= AN_OFF;
      io.seg <= SEG_BLANK;
      io.dp  <= 1'b1;
    end else begin
      io.an  <= nxt_an;
      io.seg <= nxt_seg;
      io.dp  <= nxt_dp;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at REFRESH_DIV=4.
// Expected segment patterns are hand-written per slot.
module tb_seg_scan_display;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  seg_scan_display_if dif ();

  seg_scan_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] a4, a3, a2, a1,
                        input logic lz, input logic [3:0] dps);
    dif.d4 = a4;
    dif.d3 = a3;
    dif.d2 = a2;
    dif.d1 = a1;
    dif.blank_lz = lz;
    dif.dp_sel = dps;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"}, 32'(dif.an), 32'hF);
    chk({tag, "_seg"}, 32'(dif.seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dif.dp), 32'h1);
  endtask

  // One slot: dead cycle then three active cycles.
  task automatic chk_slot(input int idx, input logic [6:0] s,
                          input logic d);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << idx);
    @(posedge clk);
    @(negedge clk);
    chk_off($sformatf("s%0d_dead", idx));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("s%0d_an%0d", idx, k), 32'(dif.an), 32'(an_exp));
      chk($sformatf("s%0d_seg%0d", idx, k), 32'(dif.seg), 32'(s));
      chk($sformatf("s%0d_dp%0d", idx, k), 32'(dif.dp), 32'(d));
    end
  endtask

  task automatic chk_frame(input logic [6:0] s0, s1, s2, s3,
                           input logic [3:0] dps);
    chk_slot(0, s0, ~dps[0]);
    chk_slot(1, s1, ~dps[1]);
    chk_slot(2, s2, ~dps[2]);
    chk_slot(3, s3, ~dps[3]);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);

    // reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(4'(i + 5), 4'(i), 4'h8, 4'(9 - i), i[0], 4'(i * 5));
      chk_off($sformatf("rst%0d", i));
    end

    @(negedge clk);
    set_in(4'h4, 4'h3, 4'h2, 4'h1, 1'b0, 4'h0);
    rst = 1'b1;
    chk_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);
    chk_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);

    // leading-zero blanking
    set_in(4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 4'h0);
    chk_frame(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'h0);
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0);
    chk_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'h0);
    set_in(4'h0, 4'h7, 4'h0, 4'h1, 1'b1, 4'h0);
    chk_frame(7'h79, 7'h40, 7'h78, 7'h7F, 4'h0);

    // inputs change mid-frame: no tearing
    set_in(4'h4, 4'h3, 4'h2, 4'h1, 1'b0, 4'h0);
    chk_slot(0, 7'h79, 1'b1);
    set_in(4'h9, 4'h9, 4'h9, 4'h9, 1'b0, 4'h0);
    chk_slot(1, 7'h24, 1'b1);
    chk_slot(2, 7'h30, 1'b1);
    chk_slot(3, 7'h19, 1'b1);
    chk_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'h0);

    // special codes and decimal point (blanked digit keeps its dp)
    set_in(4'hB, 4'hC, 4'hC, 4'hA, 1'b0, 4'b0010);
    chk_frame(7'h3F, 7'h2F, 7'h2F, 7'h06, 4'b0010);
    set_in(4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 4'b1000);
    chk_frame(7'h30, 7'h7F, 7'h7F, 7'h7F, 4'b1000);

    // asynchronous reset in slot idx2
    set_in(4'hB, 4'hC, 4'hC, 4'hA, 1'b0, 4'b0010);
    chk_slot(0, 7'h3F, 1'b1);
    chk_slot(1, 7'h2F, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_off("mr_dead");
    @(posedge clk);
    @(negedge clk);
    chk("mr_pre_an", 32'(dif.an), 32'hB);
    chk("mr_pre_seg", 32'(dif.seg), 32'h2F);
    #3 rst = 1'b0;
    #1 chk_off("mr_async");
    set_in(4'h4, 4'h3, 4'h2, 4'h1, 1'b0, 4'h0);
    @(negedge clk);
    chk_off("mr_hold");
    rst = 1'b1;
    chk_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream stage of `Calculator_fsm`; drives a common-anode 4-digit seven-segment display.
- Consumes the four 4-bit digit codes `d4`..`d1` and time-multiplexes them onto shared segment lines.
- Snapshots the inputs once per frame so the display never tears.
- Applies optional leading-zero blanking and inserts one dead cycle per digit switch to prevent ghosting.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal minimum 2; benches use 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- d4  input  4  leftmost digit code (anode 3).
- d3  input  4  digit code (anode 2).
- d2  input  4  digit code (anode 1).
- d1  input  4  rightmost digit code (anode 0).
- blank_lz  input  1  1 = blank leading zeros.
- dp_sel  input  4  decimal-point enable per anode, bit i = anode i.
- an  output  4  anode enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, idx=0, snapshot=0, an=4'hF, seg=7'h7F, dp=1.
- Prescaler cnt runs 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt returns to 0 and idx increments, wrapping 3->0.
  - One slot = REFRESH_DIV cycles; one frame = 4 slots. Slot order: idx0=d1/an[0], idx1=d2, idx2=d3, idx3=d4.
- Snapshot: on an edge where cnt==0 and idx==0, capture d4..d1, blank_lz and dp_sel into internal registers.
  - Inputs changed mid-frame have no visible effect until the next frame.
  - The first frame after reset release uses the inputs present at the first edge.
- Outputs are registered: an/seg/dp at edge t+1 are a function of the cnt, idx and snapshot values at t.
  - If cnt==0: an=4'hF, seg=7'h7F, dp=1 (dead cycle).
  - Else: an=~(4'b0001<<idx); seg = decode of the selected snapshot digit, or 7'h7F if blanked; dp = ~dp_sel[idx].
  - Net effect per slot at the outputs: 1 dead cycle, then REFRESH_DIV-1 active cycles, lagging the internal counter by one cycle.
- Digit code map (active-low segs):
  - 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A = minus, 7'h3F.
  - B = 'E', 7'h06.
  - C = 'r', 7'h2F.
  - D, E, F = blank, 7'h7F.
- Leading-zero blanking (from snapshot, when blank_lz=1):
  - d4 blanked if d4==0.
  - d3 blanked if d4 blanked and d3==0.
  - d2 blanked if d3 blanked and d2==0.
  - d1 is never blanked.
  - A blanked digit still honours its dp_sel bit.
- Reset mid-frame: everything returns immediately to reset values; scanning restarts at idx0 with a fresh snapshot.
- REFRESH_DIV<2 is illegal; flag it with an elaboration-time check.

Decomposition:
- Shared package holds:
  - segment constants SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_R, SEG_BLANK;
  - digit codes CODE_MINUS=4'hA, CODE_E=4'hB, CODE_R=4'hC;
  - these codes are shared with `Calculator_fsm` for error and negative-number display.
- One combinational sub-module, `seg7_decode` (4-bit code -> 7-bit active-low segs).
- The scanner, snapshot, blanking and registered output logic stay in the top module.

Test Plan (REFRESH_DIV=4):
- Reset: hold rst=0 for 3 cycles with inputs toggling -> an=F, seg=7F, dp=1 throughout; after release the first output cycle is dead.
- Digits d4..d1=4,3,2,1, blank_lz=0, dp_sel=0 -> repeating pattern {an=F; an=E seg=79 x3}, {F; D seg=24 x3}, {F; B seg=30 x3}, {F; 7 seg=19 x3}; dp=1.
- Leading zeros: inputs 0,0,0,5 with blank_lz=1 -> d1 slot seg=12; all other slots seg=7F with anode active.
  - Inputs 0,0,0,0 -> only d1 lit, seg=40.
  - Inputs 0,7,0,1 -> d4 blank; d3=78; d2=40; d1=79.
- Anti-tear: change inputs 4321 -> 9999 during slot idx1 -> remaining slots of the frame still show 2,3,4; the next frame shows seg=10 on all four.
- Codes and dp: inputs B,C,C,A with dp_sel=4'b0010 -> segs 06, 2F, 2F, 3F on an[3..0]; dp=0 only while an=D.
- Mid-operation reset: assert rst during slot idx2 -> outputs go to reset values without waiting for a clock; after release scanning restarts at an=E after one dead cycle.
